// File: rtl/alu_seq_ctrl.sv
// Moore sequencer for the 16-bit register-file/ALU datapath: one command per handshake,
// reads into A/B, executes into C, writes back. Define ALU_SEQ_CMP_EN to execute CMP on the ALU.
module alu_seq_ctrl #(
    parameter int RW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_type,
    input  logic [1:0]    cmd_aluop,
    input  logic [RW-1:0] cmd_rn,
    input  logic [RW-1:0] cmd_rm,
    input  logic [RW-1:0] cmd_rd,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic [1:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cmd_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WRITE_C, S_WRITE_IMM, S_DONE
    } state_t;

    localparam logic [1:0] T_MOVI = 2'b00;
    localparam logic [1:0] T_MOVR = 2'b01;
    localparam logic [1:0] T_ALU  = 2'b10;
    localparam logic [1:0] T_CMP  = 2'b11;
    localparam logic [1:0] OP_NOT = 2'b11;

    state_t        state_q, state_d;
    logic [1:0]    type_q, aluop_q;
    logic [RW-1:0] rn_q, rm_q, rd_q;
    logic [CW-1:0] count_q;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
                if (cmd_valid) begin
                    case (cmd_type)
                        T_MOVI:  state_d = S_WRITE_IMM;
                        T_MOVR:  state_d = S_LOAD_B;
                        T_ALU:   state_d = (cmd_aluop == OP_NOT) ? S_LOAD_B : S_LOAD_A;
`ifdef ALU_SEQ_CMP_EN
                        default: state_d = S_LOAD_A;
`else
                        default: state_d = S_DONE;
`endif
                    endcase
                end
            end
            S_LOAD_A:    state_d = S_LOAD_B;
            S_LOAD_B:    state_d = S_EXEC;
            // CMP only sets status, so it skips write-back
            S_EXEC:      state_d = (type_q == T_CMP) ? S_DONE : S_WRITE_C;
            S_WRITE_C:   state_d = S_DONE;
            S_WRITE_IMM: state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            aluop_q <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid) begin
                type_q  <= cmd_type;
                aluop_q <= cmd_aluop;
                rn_q    <= cmd_rn;
                rm_q    <= cmd_rm;
                rd_q    <= cmd_rd;
            end
            // Counting on entry to DONE makes the new total visible alongside the done pulse
            if (state_d == S_DONE)
                count_q <= count_q + CW'(1);
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        ALUop     = 2'b00;
        loadc     = 1'b0;
        loads     = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_LOAD_A: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_LOAD_B: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                loadc = (type_q != T_CMP);
                loads = (type_q != T_MOVR);
                asel  = (type_q == T_MOVR);
                if (type_q == T_MOVR)
                    ALUop = 2'b00;
                else if (type_q == T_CMP)
                    ALUop = 2'b01;
                else
                    ALUop = aluop_q;
            end
            S_WRITE_C: begin
                writenum = rd_q;
                write    = 1'b1;
            end
            S_WRITE_IMM: begin
                writenum = rd_q;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
`ifdef ALU_SEQ_CMP_EN
                err  = 1'b0;
`else
                err  = (type_q == T_CMP);
`endif
            end
            default: ;
        endcase
        // Strobes are masked while reset is held so the reset cycle never writes
        if (reset) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
            done  = 1'b0;
            err   = 1'b0;
        end
    end

    assign cmd_count = count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: per-command expected traces come from a command-level
// model (which reads, which execute, which write-back), compared cycle by cycle.
module tb_alu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [1:0]  cmd_aluop;
    logic [2:0]  cmd_rn, cmd_rm, cmd_rd;
    logic [2:0]  readnum, writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada, loadb, asel, bsel;
    logic [1:0]  ALUop;
    logic        loadc, loads, done, err;
    logic [15:0] cmd_count;

    alu_seq_ctrl #(.RW(3), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_aluop(cmd_aluop),
        .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .done(done), .err(err), .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
        logic        done;
        logic        err;
        logic [15:0] count;
    } outs_t;

    typedef struct packed {
        logic [1:0] t;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rm;
        logic [2:0] rd;
    } cmd_t;

    outs_t       exp_q[$];
    outs_t       obs_q[$];
    bit          vld_q[$];
    cmd_t        cmd_q[$];
    logic [15:0] exp_count;
    int          checks;
    int          errors;
    bit          cmp_en;

    function automatic cmd_t mk(input logic [1:0] t, input logic [1:0] op,
                                input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd);
        cmd_t c;
        c.t = t; c.op = op; c.rn = rn; c.rm = rm; c.rd = rd;
        return c;
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.ready = cmd_ready; s.readnum = readnum; s.writenum = writenum; s.write = write;
        s.vsel = vsel; s.loada = loada; s.loadb = loadb; s.asel = asel; s.bsel = bsel;
        s.aluop = ALUop; s.loadc = loadc; s.loads = loads; s.done = done; s.err = err;
        s.count = cmd_count;
        return s;
    endfunction

    // Reference: accept cycle, then the datapath steps the command needs, then the done cycle.
    function automatic void build_exp(input cmd_t c);
        outs_t s;
        bit imm, bypass, reads_a, writes_c;
        imm      = (c.t == 2'b00);
        bypass   = (c.t == 2'b11) && !cmp_en;
        reads_a  = (c.t == 2'b10 && c.op != 2'b11) || (c.t == 2'b11);
        writes_c = (c.t == 2'b01) || (c.t == 2'b10);
        s = '0; s.ready = 1'b1; s.count = exp_count; exp_q.push_back(s);
        if (imm) begin
            s = '0; s.writenum = c.rd; s.vsel = 2'b10; s.write = 1'b1; s.count = exp_count;
            exp_q.push_back(s);
        end else if (!bypass) begin
            if (reads_a) begin
                s = '0; s.readnum = c.rn; s.loada = 1'b1; s.count = exp_count; exp_q.push_back(s);
            end
            s = '0; s.readnum = c.rm; s.loadb = 1'b1; s.count = exp_count; exp_q.push_back(s);
            s = '0; s.loadc = writes_c; s.asel = (c.t == 2'b01); s.loads = (c.t != 2'b01);
            s.aluop = (c.t == 2'b01) ? 2'b00 : (c.t == 2'b11) ? 2'b01 : c.op;
            s.count = exp_count; exp_q.push_back(s);
            if (writes_c) begin
                s = '0; s.writenum = c.rd; s.write = 1'b1; s.count = exp_count; exp_q.push_back(s);
            end
        end
        exp_count = exp_count + 16'd1;
        s = '0; s.done = 1'b1; s.err = bypass; s.count = exp_count; exp_q.push_back(s);
    endfunction

    // Plays queued commands against the expected trace; non-accept cycles carry junk fields.
    task automatic run_cmds(input bit hold);
        outs_t fin;
        cmd_t  c;
        fin = '0; fin.ready = 1'b1; fin.count = exp_count; exp_q.push_back(fin);
        obs_q.delete();
        vld_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].ready && cmd_q.size() > 0) begin
                c = cmd_q.pop_front();
                cmd_valid = 1'b1; cmd_type = c.t; cmd_aluop = c.op;
                cmd_rn = c.rn; cmd_rm = c.rm; cmd_rd = c.rd;
            end else begin
                cmd_valid = hold && (cmd_q.size() > 0);
                cmd_type = 2'($urandom); cmd_aluop = 2'($urandom);
                cmd_rn = 3'($urandom); cmd_rm = 3'($urandom); cmd_rd = 3'($urandom);
            end
            #1;
            obs_q.push_back(sample());
            vld_q.push_back(cmd_valid);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        outs_t idle;
        reset = 1'b1; cmd_valid = 1'b1; cmd_type = 2'b00; cmd_rd = 3'd6;
        #1;
        checks++;
        if ({write, loada, loadb, loadc, loads, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 0000000", {write, loada, loadb, loadc, loads, done, err});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0;
        exp_count = 16'd0;
        idle = '0; idle.ready = 1'b1;
        #1;
        checks++;
        if (sample() !== idle) begin
            errors++;
            $display("FAIL reset_idle: got %h required %h", sample(), idle);
        end
        @(negedge clk);
    endtask

    task automatic test_movi();
        exp_q.delete();
        cmd_q.push_back(mk(2'b00, 2'b01, 3'd7, 3'd6, 3'd3));
        build_exp(mk(2'b00, 2'b01, 3'd7, 3'd6, 3'd3));
        run_cmds(1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL movi cyc%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alu_add();
        exp_q.delete();
        cmd_q.push_back(mk(2'b10, 2'b00, 3'd1, 3'd2, 3'd5));
        build_exp(mk(2'b10, 2'b00, 3'd1, 3'd2, 3'd5));
        run_cmds(1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL alu_add cyc%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alu_not();
        int n_loada;
        exp_q.delete();
        cmd_q.push_back(mk(2'b10, 2'b11, 3'd6, 3'd4, 3'd0));
        build_exp(mk(2'b10, 2'b11, 3'd6, 3'd4, 3'd0));
        run_cmds(1'b0);
        n_loada = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].loada) n_loada++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL alu_not cyc%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_loada != 0) begin
            errors++;
            $display("FAIL alu_not_loada: got %0d loada cycles required 0", n_loada);
        end
    endtask

    task automatic test_back_to_back();
        int accepts, dones;
        cmd_t c;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            c = mk(2'b01, 2'($urandom), 3'($urandom), 3'(k + 1), 3'(k + 4));
            cmd_q.push_back(c);
            build_exp(c);
        end
        run_cmds(1'b1);
        accepts = 0; dones = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i].ready && vld_q[i]) accepts++;
            if (obs_q[i].done) dones++;
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL back_to_back cyc%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (accepts != 3 || dones != 3) begin
            errors++;
            $display("FAIL b2b_counts: got %0d accepts %0d dones required 3 and 3", accepts, dones);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_aluop = 2'b00;
        cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_rd = 3'd5;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ready: got %b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (loadc !== 1'b1 || loads !== 1'b1) begin
            errors++;
            $display("FAIL rmid_exec: got loadc=%b loads=%b required 1 1", loadc, loads);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({write, loada, loadb, loadc, loads, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL rmid_gate: got %b required 0000000", {write, loada, loadb, loadc, loads, done, err});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_count = 16'd0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || cmd_count !== 16'd0) begin
            errors++;
            $display("FAIL rmid_after: got ready=%b count=%0d required 1 0", cmd_ready, cmd_count);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || write !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet cyc%0d: got done=%b write=%b required 0 0", i, done, write);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_cmp();
        int n_write, n_loads;
        exp_q.delete();
        cmd_q.push_back(mk(2'b11, 2'b10, 3'd2, 3'd2, 3'd1));
        build_exp(mk(2'b11, 2'b10, 3'd2, 3'd2, 3'd1));
        run_cmds(1'b0);
        n_write = 0; n_loads = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i].write) n_write++;
            if (obs_q[i].loads) n_loads++;
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL cmp cyc%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_write != 0 || n_loads != (cmp_en ? 1 : 0)) begin
            errors++;
            $display("FAIL cmp_strobes: got write=%0d loads=%0d required 0 %0d", n_write, n_loads, cmp_en ? 1 : 0);
        end
    endtask

    task automatic test_random();
        cmd_t c;
        for (int n = 0; n < 40; n++) begin
            c = mk(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            exp_q.delete();
            cmd_q.push_back(c);
            build_exp(c);
            run_cmds(1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random cmd%0d t=%0d op=%0d cyc%0d: got %h required %h",
                             n, c.t, c.op, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = 16'd0;
`ifdef ALU_SEQ_CMP_EN
        cmp_en = 1'b1;
`else
        cmp_en = 1'b0;
`endif
        reset = 1'b0; cmd_valid = 1'b0;
        cmd_type = 2'b00; cmd_aluop = 2'b00; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_rd = 3'd0;
        @(negedge clk);
        test_reset();
        test_movi();
        test_alu_add();
        test_alu_not();
        test_back_to_back();
        test_reset_mid();
        test_cmp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
